// File: rtl/cgra_pkg.sv
// Shared CGRA constants and the TCDM request bundle that the port arbiter muxes.
package cgra_pkg;

    localparam int N_COL               = 4;
    localparam int DATA_BUS_ADD_WIDTH  = 32;
    localparam int DATA_BUS_DATA_WIDTH = 32;
    localparam int TCDM_ARB_MAX_OUTST  = 4;

    typedef struct packed {
        logic [DATA_BUS_ADD_WIDTH-1:0]  add;
        logic                           wen;
        logic [3:0]                     be;
        logic [DATA_BUS_DATA_WIDTH-1:0] wdata;
    } tcdm_req_t;

endpackage

// File: rtl/cgra_id_fifo.sv
// Small FIFO that records which requester owns each granted-but-unanswered transaction.
module cgra_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cgra_tcdm_port_arbiter.sv
// Round-robin sharing of one TCDM master port between N_REQ column requesters,
// with in-order response routing through a requester-ID FIFO.
module cgra_tcdm_port_arbiter
    import cgra_pkg::*;
#(
    parameter int N_REQ      = N_COL,
    parameter int ADDR_WIDTH = DATA_BUS_ADD_WIDTH,
    parameter int DATA_WIDTH = DATA_BUS_DATA_WIDTH,
    parameter int MAX_OUTST  = TCDM_ARB_MAX_OUTST
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_REQ-1:0]                 req_i,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] add_i,
    input  logic [N_REQ-1:0]                 wen_i,
    input  logic [N_REQ-1:0][3:0]            be_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]                 gnt_o,
    output logic [N_REQ-1:0]                 rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             bus_req_o,
    output logic [ADDR_WIDTH-1:0]            bus_add_o,
    output logic                             bus_wen_o,
    output logic [3:0]                       bus_be_o,
    output logic [DATA_WIDTH-1:0]            bus_wdata_o,
    input  logic                             bus_gnt_i,
    input  logic [DATA_WIDTH-1:0]            bus_rdata_i,
    input  logic                             bus_rvalid_i,
    output logic [$clog2(MAX_OUTST):0]       outst_o,
    output logic                             err_o
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           err_q, err_d;
    logic [IDW-1:0] win_id, head_id;
    logic [IDW:0]   idx_w;
    logic           win_found;
    logic           fifo_full, fifo_empty;
    logic           hs, pop;
    tcdm_req_t      win_req;

    // First requester at or after rr_ptr, wrapping mod N_REQ.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        idx_w     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_w = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(N_REQ)) begin
                idx_w = idx_w - (IDW+1)'(N_REQ);
            end
            if (!win_found && req_i[idx_w[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx_w[IDW-1:0];
            end
        end
    end

    // Handshake: a transaction is transferred in any cycle where bus_req_o and bus_gnt_i are
    // both high; the winner sees gnt_o that same cycle and must hold its fields until then.
    assign bus_req_o = win_found & ~fifo_full & ~rst_i;
    assign hs        = bus_req_o & bus_gnt_i;
    assign pop       = bus_rvalid_i & ~fifo_empty & ~rst_i;

    always_comb begin
        win_req = '0;
        if (bus_req_o) begin
            win_req.add   = add_i[win_id];
            win_req.wen   = wen_i[win_id];
            win_req.be    = be_i[win_id];
            win_req.wdata = wdata_i[win_id];
        end
    end

    assign bus_add_o   = win_req.add;
    assign bus_wen_o   = win_req.wen;
    assign bus_be_o    = win_req.be;
    assign bus_wdata_o = win_req.wdata;

    assign gnt_o    = hs  ? (N_REQ'(1) << win_id)  : '0;
    assign rvalid_o = pop ? (N_REQ'(1) << head_id) : '0;
    assign rdata_o  = bus_rdata_i;
    assign err_o    = err_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);
        end
        err_d = err_q | (bus_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    cgra_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (win_id),
        .pop_i   (pop),
        .head_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outst_o)
    );

endmodule

// File: tb/tb_cgra_tcdm_port_arbiter.sv
// Randomised and directed scoreboard bench for the TCDM port arbiter.
module tb_cgra_tcdm_port_arbiter;

    localparam int N  = 4;
    localparam int MO = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_i;
    logic [N-1:0][31:0] add_i;
    logic [N-1:0]      wen_i;
    logic [N-1:0][3:0] be_i;
    logic [N-1:0][31:0] wdata_i;
    logic [N-1:0]      gnt_o, rvalid_o;
    logic [31:0]       rdata_o;
    logic              bus_req_o, bus_wen_o;
    logic [31:0]       bus_add_o, bus_wdata_o;
    logic [3:0]        bus_be_o;
    logic              bus_gnt_i, bus_rvalid_i;
    logic [31:0]       bus_rdata_i;
    logic [2:0]        outst_o;
    logic              err_o;

    cgra_tcdm_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .bus_req_o(bus_req_o), .bus_add_o(bus_add_o), .bus_wen_o(bus_wen_o), .bus_be_o(bus_be_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rdata_i(bus_rdata_i),
        .bus_rvalid_i(bus_rvalid_i), .outst_o(outst_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Expected grants: {id[70:69], wen[68], be[67:64], add[63:32], wdata[31:0]}
    logic [70:0] exp_gnt_q[$];
    // Expected responses: {id[33:32], rdata[31:0]}
    logic [33:0] exp_rsp_q[$];

    // Reference model: pending owners in grant order, round-robin start, sticky error.
    int  model_q[$];
    int  m_rr;
    bit  m_err;
    int  exp_win;
    bit  exp_bus_req, exp_hs, exp_pop;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input int id);
        logic [3:0] one;
        one = 4'b0001;
        return one << id;
    endfunction

    // Called just after a rising edge: apply inputs and predict this cycle's behaviour.
    task automatic drive(input logic [3:0] req, input bit gnt, input bit rv, input logic [31:0] rdata);
        req_i = req;
        for (int i = 0; i < N; i++) begin
            add_i[i]   = $urandom;
            wen_i[i]   = 1'($urandom_range(0, 1));
            be_i[i]    = 4'($urandom_range(0, 15));
            wdata_i[i] = $urandom;
        end
        bus_gnt_i    = gnt;
        bus_rvalid_i = rv;
        bus_rdata_i  = rdata;
        exp_win = -1;
        for (int k = 0; k < N; k++) begin
            if (exp_win < 0 && req[(m_rr + k) % N]) exp_win = (m_rr + k) % N;
        end
        exp_bus_req = (exp_win >= 0) && (model_q.size() < MO);
        exp_hs      = exp_bus_req && gnt;
        exp_pop     = rv && (model_q.size() > 0);
        if (exp_hs)
            exp_gnt_q.push_back({2'(exp_win), wen_i[exp_win], be_i[exp_win], add_i[exp_win], wdata_i[exp_win]});
        if (exp_pop)
            exp_rsp_q.push_back({2'(model_q[0]), rdata});
    endtask

    task automatic advance();
        @(posedge clk_i);
        if (exp_pop) void'(model_q.pop_front());
        else if (bus_rvalid_i) m_err = 1'b1;
        if (exp_hs) begin
            model_q.push_back(exp_win);
            m_rr = (exp_win + 1) % N;
        end
        #1;
    endtask

    task automatic cyc(input logic [3:0] req, input bit gnt, input bit rv, input logic [31:0] rdata);
        drive(req, gnt, rv, rdata);
        @(negedge clk_i);
        #1;
        advance();
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && model_q.size() > 0; i++) cyc(4'h0, 1'b0, 1'b1, $urandom);
    endtask

    task automatic do_reset();
        mon_en       = 1'b0;
        rst_i        = 1'b1;
        req_i        = 4'hF;
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0;
        add_i = '0; wen_i = '0; be_i = '0; wdata_i = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            #1;
            check("rst_gnt", gnt_o, 0);
            check("rst_rvalid", rvalid_o, 0);
            check("rst_bus_req", bus_req_o, 0);
            check("rst_outst", outst_o, 0);
            check("rst_err", err_o, 0);
        end
        req_i = 4'h0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        rst_i = 1'b0;
        model_q.delete();
        exp_gnt_q.delete();
        exp_rsp_q.delete();
        m_rr = 0; m_err = 1'b0; exp_bus_req = 1'b0; exp_hs = 1'b0; exp_pop = 1'b0;
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a grant or a response.
    always @(negedge clk_i) begin
        logic [70:0] ge;
        logic [33:0] re;
        if (mon_en) begin
            if (gnt_o != 4'h0) begin
                if (exp_gnt_q.size() == 0) check("gnt_unexpected", gnt_o, 0);
                else begin
                    ge = exp_gnt_q.pop_front();
                    check("gnt_id", gnt_o, onehot(int'(ge[70:69])));
                    check("bus_add", bus_add_o, ge[63:32]);
                    check("bus_wen", bus_wen_o, ge[68]);
                    check("bus_be", bus_be_o, ge[67:64]);
                    check("bus_wdata", bus_wdata_o, ge[31:0]);
                end
            end
            if (rvalid_o != 4'h0) begin
                if (exp_rsp_q.size() == 0) check("rvalid_unexpected", rvalid_o, 0);
                else begin
                    re = exp_rsp_q.pop_front();
                    check("rvalid_id", rvalid_o, onehot(int'(re[33:32])));
                    check("rdata", rdata_o, re[31:0]);
                end
            end
            check("bus_req", bus_req_o, exp_bus_req);
            check("outst", outst_o, model_q.size());
            check("err", err_o, m_err);
            check("rdata_pass", rdata_o, bus_rdata_i);
            if (!exp_bus_req) check("bus_idle", {bus_add_o, bus_wen_o, bus_be_o, bus_wdata_o}, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd_tab [3];
        logic [3:0]  id_tab [3];
        int first_id;
        rd_tab[0] = 32'hA5A5_0001; rd_tab[1] = 32'h5A5A_0002; rd_tab[2] = 32'hC3C3_0003;
        id_tab[0] = 4'b0100;       id_tab[1] = 4'b0001;       id_tab[2] = 4'b1000;

        do_reset();

        // Fairness: all requesting, bus always granting, one response per cycle after the first.
        for (int i = 0; i < 8; i++) begin
            drive(4'hF, 1'b1, i > 0, $urandom);
            @(negedge clk_i);
            #1;
            check("fair_gnt", gnt_o, onehot(i % N));
            check("fair_add", bus_add_o, add_i[i % N]);
            advance();
        end
        drain();

        // Full: four grants with no responses.
        for (int i = 0; i < MO; i++) cyc(4'($urandom_range(1, 15)), 1'b1, 1'b0, $urandom);
        drive(4'hF, 1'b1, 1'b0, $urandom);
        @(negedge clk_i); #1;
        check("full_outst", outst_o, 4);
        check("full_bus_req", bus_req_o, 0);
        check("full_gnt", gnt_o, 0);
        advance();
        first_id = model_q[0];
        drive(4'hF, 1'b1, 1'b1, $urandom);
        @(negedge clk_i); #1;
        check("full_pop_bus_req", bus_req_o, 0);
        check("full_pop_rvalid", rvalid_o, onehot(first_id));
        advance();
        drive(4'hF, 1'b0, 1'b0, $urandom);
        @(negedge clk_i); #1;
        check("resume_bus_req", bus_req_o, 1);
        check("resume_outst", outst_o, 3);
        advance();
        drain();

        // Ordering: grants to 2, 0, 3 then three responses.
        cyc(4'b0100, 1'b1, 1'b0, $urandom);
        cyc(4'b0001, 1'b1, 1'b0, $urandom);
        cyc(4'b1000, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 3; i++) begin
            drive(4'h0, 1'b0, 1'b1, rd_tab[i]);
            @(negedge clk_i); #1;
            check("order_rvalid", rvalid_o, id_tab[i]);
            check("order_rdata", rdata_o, rd_tab[i]);
            advance();
        end

        // Simultaneous grant and response at two outstanding.
        cyc(4'b0001, 1'b1, 1'b0, $urandom);
        cyc(4'b0010, 1'b1, 1'b0, $urandom);
        drive(4'b0100, 1'b1, 1'b1, $urandom);
        @(negedge clk_i); #1;
        check("simul_rvalid", rvalid_o, 4'b0001);
        check("simul_gnt", gnt_o, 4'b0100);
        advance();
        check("simul_outst", outst_o, 2);
        drain();

        // Stray response with nothing outstanding.
        drive(4'h0, 1'b0, 1'b1, $urandom);
        @(negedge clk_i); #1;
        check("stray_rvalid", rvalid_o, 0);
        advance();
        check("stray_err", err_o, 1);
        for (int i = 0; i < 5; i++) cyc(4'h0, 1'b0, 1'b0, $urandom);
        check("err_sticky", err_o, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                (model_q.size() > 0) && ($urandom_range(0, 2) != 0), $urandom);
        end
        check("rnd_err_sticky", err_o, 1);

        // Reset with transactions in flight, then a fresh transaction from ID 0.
        cyc(4'hF, 1'b1, 1'b0, $urandom);
        cyc(4'hF, 1'b1, 1'b0, $urandom);
        do_reset();
        cyc(4'hF, 1'b1, 1'b0, $urandom);
        drain();

        check("gnt_left", exp_gnt_q.size(), 0);
        check("rsp_left", exp_rsp_q.size(), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
